// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared op and state encodings for the multi-cycle mul/div unit.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mcycle_pkg;

    typedef enum logic [1:0] {
        MUL_U = 2'b00,
        MUL_S = 2'b01,
        DIV_U = 2'b10,
        DIV_S = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        FINISH  = 2'b10
    } mcycle_state_e;

    // Bit 1 of the op selects divide, bit 0 selects two's-complement operands.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mcycle_sign_fix.sv
// mcycle_sign_fix: conditional two's-complement negate (abs on the way in, sign restore on the way out).
// Latency: combinational.
// Backpressure: none.
module mcycle_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    // Negate when requested; the most-negative value maps onto itself, which is exactly the wrap we want.
    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiplier / restoring divider; optional MCYCLE_EARLY_EXIT_EN shortens mul and div-by-zero.
// Latency: Done WIDTH+1 edges after Start is sampled (sampling edge counted), results then held until the next Done.
// Backpressure: none; Start is ignored while Busy and accepted in IDLE or in the Done cycle (back-to-back).
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH);

    mcycle_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               dz_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   op1_q;

    // Multiply datapath: multiplier shifts right, multiplicand shifts left into a 2W accumulator.
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    // Divide datapath: dividend shifts out of quo_q MSB-first while quotient bits shift in.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q;

    logic [WIDTH-1:0]   res1_q, res2_q;
    logic               busy_q, done_q, dbz_q;

    logic               op1_neg, op2_neg, start_dz;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic               last_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign Result1   = res1_q;
    assign Result2   = res2_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;

    // Decode operand signs and the zero-divisor case from the live inputs at Start.
    always_comb begin
        op1_neg  = op_is_signed(MCycleOp) & Operand1[WIDTH-1];
        op2_neg  = op_is_signed(MCycleOp) & Operand2[WIDTH-1];
        start_dz = op_is_div(MCycleOp) & (Operand2 == '0);
    end

    mcycle_sign_fix #(.W(WIDTH)) u_abs_op1 (.val_i(Operand1), .neg_i(op1_neg), .val_o(op1_mag));
    mcycle_sign_fix #(.W(WIDTH)) u_abs_op2 (.val_i(Operand2), .neg_i(op2_neg), .val_o(op2_mag));

    // One iteration of both datapaths; the FSM only commits the one matching the latched op.
    always_comb begin
        prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        // When div_ge holds the true difference is below the divisor, so W bits are enough.
        div_diff  = div_shift[WIDTH-1:0] - dvs_q;
        rem_d     = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], div_ge};
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MCYCLE_EARLY_EXIT_EN
        // Once no multiplier bits remain, further steps cannot change the product.
        if (!is_div_q && (mplier_d == '0)) begin
            last_step = 1'b1;
        end
`endif
    end

    // Restore signs on the values the final step produces so results load straight into FINISH.
    mcycle_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val_i(prod_d), .neg_i(neg_res_q), .val_o(prod_fix));
    mcycle_sign_fix #(.W(WIDTH))   u_fix_quo  (.val_i(quo_d),  .neg_i(neg_res_q), .val_o(quo_fix));
    mcycle_sign_fix #(.W(WIDTH))   u_fix_rem  (.val_i(rem_d),  .neg_i(neg_rem_q), .val_o(rem_fix));

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op1_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            res1_q    <= '0;
            res2_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    if (Start) begin
                        cnt_q     <= '0;
                        is_div_q  <= op_is_div(MCycleOp);
                        dz_q      <= start_dz;
                        neg_res_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                        op1_q     <= Operand1;
                        mplier_q  <= op2_mag;
                        mcand_q   <= {{WIDTH{1'b0}}, op1_mag};
                        prod_q    <= '0;
                        quo_q     <= op1_mag;
                        rem_q     <= '0;
                        dvs_q     <= op2_mag;
`ifdef MCYCLE_EARLY_EXIT_EN
                        if (start_dz) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            res1_q  <= '1;
                            res2_q  <= Operand1;
                        end else begin
                            state_q <= COMPUTE;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= COMPUTE;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                COMPUTE: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    mplier_q <= mplier_d;
                    mcand_q  <= mcand_d;
                    prod_q   <= prod_d;
                    quo_q    <= quo_d;
                    rem_q    <= rem_d;
                    if (last_step) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= dz_q;
                        if (dz_q) begin
                            res1_q <= '1;
                            res2_q <= op1_q;
                        end else if (is_div_q) begin
                            res1_q <= quo_fix;
                            res2_q <= rem_fix;
                        end else begin
                            {res2_q, res1_q} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed corner cases plus randomized ops on 32- and 8-bit instances against an arithmetic model.
// Latency: expected Start->Done edge counts come from the model (MCYCLE_EARLY_EXIT_EN aware).
// Backpressure: n/a.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32, s8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32, r1_32, r2_32;
    logic [7:0]  a8, b8, r1_8, r2_8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    int total = 0;
    int bad   = 0;

    mcycle_unit #(.WIDTH(32)) u_dut32 (
        .CLK(clk), .Reset(rst), .Start(s32), .MCycleOp(op32),
        .Operand1(a32), .Operand2(b32), .Result1(r1_32), .Result2(r2_32),
        .Busy(busy32), .Done(done32), .DivByZero(dz32)
    );

    mcycle_unit #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .Reset(rst), .Start(s8), .MCycleOp(op8),
        .Operand1(a8), .Operand2(b8), .Result1(r1_8), .Result2(r2_8),
        .Busy(busy8), .Done(done8), .DivByZero(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            s8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; s32 = 1'b0;
        end else begin
            s32 = st; op32 = op; a32 = a; b32 = b; s8 = 1'b0;
        end
    endtask

    // Reference: plain integer arithmetic on sign-extended operands, C-style truncating division.
    function automatic void model(input bit w8, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r1, output logic [31:0] r2,
                                  output logic dz, output int lat);
        int w;
        longint unsigned mask, ua, ub, p;
        longint sa, sb;
`ifdef MCYCLE_EARLY_EXIT_EN
        longint mb;
        int bits;
`endif
        w    = w8 ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = (op[0] && ua[w-1]) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = (op[0] && ub[w-1]) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        dz   = 1'b0;
        if (!op[1]) begin
            p  = $unsigned(sa) * $unsigned(sb);
            r1 = 32'(p & mask);
            r2 = 32'((p >> w) & mask);
        end else if (ub == 0) begin
            r1 = 32'(mask);
            r2 = 32'(ua);
            dz = 1'b1;
        end else if (op[0]) begin
            r1 = 32'($unsigned(sa / sb) & mask);
            r2 = 32'($unsigned(sa % sb) & mask);
        end else begin
            r1 = 32'(ua / ub);
            r2 = 32'(ua % ub);
        end
        lat = w + 1;
`ifdef MCYCLE_EARLY_EXIT_EN
        if (op[1] && ub == 0) begin
            lat = 1;
        end else if (!op[1]) begin
            mb   = (sb < 0) ? -sb : sb;
            bits = 0;
            while (mb != 0) begin
                bits++;
                mb = mb >> 1;
            end
            if (bits == 0) bits = 1;
            lat = bits + 1;
        end
`endif
    endfunction

    // Issue one op, count edges (sampling edge = 1) until Done, check against the model.
    // poke_at > 0 pulses Start with unrelated operands at that edge count while the op runs.
    task automatic run_op(input string tag, input bit w8, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int poke_at,
                          output logic [31:0] r1, output logic [31:0] r2,
                          output logic dz, output int lat);
        logic [31:0] e1, e2;
        logic        edz, cb, cd;
        int          elat, n, busy_n;
        bit          seen;
        model(w8, op, a, b, e1, e2, edz, elat);
        drive(w8, 1'b1, op, a, b);
        n = 0; busy_n = 0; seen = 0;
        cb = 1'b0; cd = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            cb = w8 ? busy8 : busy32;
            cd = w8 ? done8 : done32;
            if (n == 1) begin
                drive(w8, 1'b0, op, a, b);
                chk({tag, "_first_done"}, 64'(cd), 64'(elat == 1));
                chk({tag, "_first_busy"}, 64'(cb), 64'(elat > 1));
            end
            if (poke_at > 0 && n == poke_at) drive(w8, 1'b1, ~op, ~a, b ^ 32'h5A5A_1234);
            if (poke_at > 0 && n == poke_at + 1) drive(w8, 1'b0, op, a, b);
            if (cd) seen = 1;
            else if (cb) busy_n++;
        end
        r1  = w8 ? {24'd0, r1_8} : r1_32;
        r2  = w8 ? {24'd0, r2_8} : r2_32;
        dz  = w8 ? dz8 : dz32;
        lat = n;
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_busycyc"}, 64'(busy_n), 64'(elat - 1));
        chk({tag, "_busy_at_done"}, 64'(cb), 64'(0));
        chk({tag, "_r1"}, 64'(r1), 64'(e1));
        chk({tag, "_r2"}, 64'(r2), 64'(e2));
        chk({tag, "_dz"}, 64'(dz), 64'(edz));
    endtask

    function automatic logic [31:0] pick(input bit w8);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = w8 ? 32'h80 : 32'h8000_0000;
            4:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return w8 ? (v & 32'hFF) : v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2;
        logic        dz;
        int          lat, gap;
        bit          w8;
        logic [1:0]  op;

        rst = 1'b1;
        s32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        s8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy32", 64'(busy32), 0);
        chk("rst_done32", 64'(done32), 0);
        chk("rst_dz32",   64'(dz32),   0);
        chk("rst_r1_32",  64'(r1_32),  0);
        chk("rst_r2_32",  64'(r2_32),  0);
        chk("rst_busy8",  64'(busy8),  0);
        chk("rst_r1_8",   64'(r1_8),   0);

        // Reset wins over a simultaneous Start.
        drive(0, 1'b1, MUL_U, 32'd5, 32'd5);
        @(posedge clk); #1;
        chk("rst_prio_busy", 64'(busy32), 0);
        chk("rst_prio_done", 64'(done32), 0);
        drive(0, 1'b0, MUL_U, 32'd5, 32'd5);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mulff", 0, MUL_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r1, r2, dz, lat);
        chk("mulff_r2_lit", 64'(r2), 64'h0000_0000_FFFF_FFFE);
        chk("mulff_r1_lit", 64'(r1), 64'h0000_0000_0000_0001);
        chk("mulff_lat_lit", 64'(lat), 64'd33);

        // Back-to-back: each of these is issued in the previous op's Done cycle.
        run_op("divs7", 0, DIV_S, 32'hFFFF_FFF9, 32'd2, 0, r1, r2, dz, lat);
        chk("divs7_r1_lit", 64'(r1), 64'h0000_0000_FFFF_FFFD);
        chk("divs7_r2_lit", 64'(r2), 64'h0000_0000_FFFF_FFFF);
        chk("divs7_lat_b2b", 64'(lat), 64'd33);

        run_op("divmn", 0, DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 0, r1, r2, dz, lat);
        chk("divmn_r1_lit", 64'(r1), 64'h0000_0000_8000_0000);
        chk("divmn_r2_lit", 64'(r2), 64'd0);
        chk("divmn_dz_lit", 64'(dz), 64'd0);

        run_op("div0", 0, DIV_U, 32'd123, 32'd0, 0, r1, r2, dz, lat);
        chk("div0_r1_lit", 64'(r1), 64'h0000_0000_FFFF_FFFF);
        chk("div0_r2_lit", 64'(r2), 64'd123);
        chk("div0_dz_lit", 64'(dz), 64'd1);
`ifdef MCYCLE_EARLY_EXIT_EN
        chk("div0_lat_lit", 64'(lat), 64'd1);
`else
        chk("div0_lat_lit", 64'(lat), 64'd33);
`endif

        // Start pulsed mid-COMPUTE must not disturb the running divide.
        repeat (2) begin @(posedge clk); #1; end
        run_op("poke", 0, DIV_U, 32'd1_000_000, 32'd7, 5, r1, r2, dz, lat);
        chk("poke_r1_lit", 64'(r1), 64'd142857);
        chk("poke_r2_lit", 64'(r2), 64'd1);
        @(posedge clk); #1;
        chk("poke_hold_r1", 64'(r1_32), 64'd142857);

        // Reset at COMPUTE cycle 10.
        drive(0, 1'b1, MUL_U, 32'h1234_5678, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, MUL_U, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        chk("midrst_busy_before", 64'(busy32), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy32), 0);
        chk("midrst_done", 64'(done32), 0);
        chk("midrst_r1",   64'(r1_32),  0);
        chk("midrst_r2",   64'(r2_32),  0);
        run_op("mul67", 0, MUL_U, 32'd6, 32'd7, 0, r1, r2, dz, lat);
        chk("mul67_r1_lit", 64'(r1), 64'd42);

        run_op("m8", 1, MUL_S, 32'h80, 32'h80, 0, r1, r2, dz, lat);
        chk("m8_r2_lit", 64'(r2), 64'h40);
        chk("m8_r1_lit", 64'(r1), 64'h00);
        chk("m8_lat_lit", 64'(lat), 64'd9);

        for (int i = 0; i < 48; i++) begin
            w8  = ($urandom_range(0, 3) == 0);
            op  = 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            run_op($sformatf("rnd%0d", i), w8, op, pick(w8), pick(w8), 0, r1, r2, dz, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (even, >= 4).
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Start  input  1  request to begin an operation.
REQ-005 SHALL have port MCycleOp  input  2  op: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
REQ-006 SHALL have ports Operand1, Operand2  input  WIDTH each  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have ports Result1, Result2  output  WIDTH each  mul: low/high product; div: quotient/remainder.
REQ-008 SHALL have port Busy  output  1  high while iterating.
REQ-009 SHALL have port Done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port DivByZero  output  1  qualifies Done; high when divisor was zero.

Function
REQ-011 SHALL implement states IDLE, COMPUTE, FINISH; Start sampled in IDLE or FINISH -> COMPUTE, operands/op latched, iteration counter cleared.
REQ-012 SHALL ignore Start while in COMPUTE; latched operands unaffected.
REQ-013 SHALL perform one shift-add (mul) or restoring shift-subtract (div) step per cycle; COMPUTE lasts exactly WIDTH cycles, then FINISH for one cycle.
REQ-014 SHALL drive Busy=1 exactly in COMPUTE, Done=1 exactly in FINISH; Done at edge WIDTH+1 after Start sampled.
REQ-015 SHALL compute signed ops on magnitudes; FINISH negates product/quotient if operand signs differ, remainder takes dividend sign.
REQ-016 SHALL produce full 2*WIDTH product split into Result2:Result1.
REQ-017 SHALL, for signed most-negative / -1, return quotient = most-negative (wraps), remainder 0, DivByZero 0.
REQ-018 SHALL, for divisor zero, return Result1 all-ones, Result2 = Operand1, DivByZero=1 with Done.
REQ-019 SHALL hold Result1/Result2 stable from FINISH until next accepted Start's FINISH; intermediate values not visible.
REQ-020 SHALL accept Start in FINISH cycle (back-to-back); Done then drops, Busy rises next cycle.

Reset
REQ-021 SHALL, on Reset high at a clock edge (including mid-COMPUTE), enter IDLE, clear counter, Busy=0, Done=0, DivByZero=0, Result1=Result2=0.
REQ-022 SHALL give Reset priority over simultaneous Start; Start ignored that edge.

Configuration
REQ-023 SHALL support macro MCYCLE_EARLY_EXIT_EN.
REQ-024 SHALL, with MCYCLE_EARLY_EXIT_EN defined, leave COMPUTE once remaining multiplier bits are zero (mul) and skip COMPUTE entirely on zero divisor (Start -> FINISH, Done next edge); results identical to full-latency.
REQ-025 SHALL, without MCYCLE_EARLY_EXIT_EN, use fixed WIDTH-cycle COMPUTE for all ops including divide-by-zero.

Structure
REQ-026 SHALL place op encodings (MUL_U, MUL_S, DIV_U, DIV_S) and state encoding in shared package mcycle_pkg.
REQ-027 SHALL implement abs/negate sign correction in one combinational sub-module mcycle_sign_fix, instantiated for operands and results.

Verification
REQ-028 SHALL cover WIDTH=32 unsigned mul 0xFFFFFFFF*0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001, Done 33 edges after Start, Busy high 32 cycles.
REQ-029 SHALL cover signed div -7/2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1); and 0x80000000/-1 -> Result1=0x80000000, Result2=0.
REQ-030 SHALL cover div 123/0 -> Result1=0xFFFFFFFF, Result2=123, DivByZero=1; latency 33 without macro, 1 with MCYCLE_EARLY_EXIT_EN.
REQ-031 SHALL cover Reset asserted at COMPUTE cycle 10 -> next cycle Busy=0, Done=0, results 0; subsequent 6*7 mul -> Result1=42.
REQ-032 SHALL cover Start pulsed mid-COMPUTE (ignored, original result correct) and Start held in FINISH (back-to-back second op, second Done 33 edges later).
REQ-033 SHALL cover WIDTH=8 signed mul -128*-128 -> Result2=0x40, Result1=0x00, Done 9 edges after Start.
